// File: rtl/display_frame_loader.sv
// display_frame_loader: snapshots BCD time, encodes it into a 48-bit 7-segment frame
// and hands it to the display shift register with a one-cycle start pulse.
module display_frame_loader #(
    parameter int HOLD_CYCLES    = 128,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        update_i,
    input  logic        valid_i,
    input  logic [7:0]  hh_i,
    input  logic [7:0]  mm_i,
    input  logic [7:0]  ss_i,
    output logic        start_o,
    output logic [47:0] data_o,
    output logic        busy_o
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, HOLD} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic          pending_q, pending_d;
    logic [47:0]   data_q, data_d;
    logic [47:0]   frame;
    logic          dot, capture, hold_last;

    function automatic logic [7:0] seg(input logic [3:0] n);
        case (n)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = 8'h00;
        endcase
    endfunction

    // Separator dots blink with the seconds: lit on even seconds.
    assign dot   = valid_i & ~ss_i[0];
    assign frame = valid_i ? {seg(hh_i[7:4]), {dot, 7'h00} | seg(hh_i[3:0]),
                              seg(mm_i[7:4]), {dot, 7'h00} | seg(mm_i[3:0]),
                              seg(ss_i[7:4]), seg(ss_i[3:0])}
                           : {6{8'h40}};

    assign hold_last = hold_q == HW'(HOLD_CYCLES - 1);
    assign capture   = (state_q == IDLE) &&
                       (update_i || pending_q || refresh_q == RW'(REFRESH_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        hold_d    = '0;
        refresh_d = '0;
        data_d    = capture ? frame : data_q;
        pending_d = capture ? 1'b0 : (pending_q | (update_i && state_q != IDLE));
        case (state_q)
            IDLE: begin
                state_d   = capture ? LOAD : IDLE;
                refresh_d = capture ? '0 : refresh_q + RW'(1);
            end
            LOAD: state_d = SEND;
            SEND: state_d = HOLD;
            HOLD: begin
                state_d = hold_last ? IDLE : HOLD;
                hold_d  = hold_last ? '0 : hold_q + HW'(1);
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            refresh_q <= '0;
            pending_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            refresh_q <= refresh_d;
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

    assign start_o = state_q == SEND;
    assign busy_o  = state_q != IDLE;
    assign data_o  = data_q;
endmodule
